// File: rtl/hamming_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_tx_arbiter_pkg
// Description : Shared (15,11) Hamming constants and codeword bit-position map.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_tx_arbiter_pkg;

    localparam int DATA_W = 11;
    localparam int CODE_W = 15;

    // Codeword bit index (0-based) of each data bit; position p lives in bit p-1.
    localparam logic [3:0] c_data_bit [DATA_W] = '{
        4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14
    };

    // Parity bits sit at positions 1,2,4,8; each covers positions with that bit set.
    localparam logic [3:0]        c_par_bit  [4] = '{4'd0, 4'd1, 4'd3, 4'd7};
    localparam logic [CODE_W-1:0] c_par_mask [4] = '{
        15'h5555, 15'h6666, 15'h7878, 15'h7F80
    };

endpackage : hamming_tx_arbiter_pkg
`default_nettype wire

// File: rtl/hamming1511_encoder.sv
`default_nettype none
// ============================================================================
// Module      : hamming1511_encoder
// Description : Combinational (15,11) Hamming encoder, even parity.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming1511_encoder
    import hamming_tx_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [CODE_W-1:0] o_code
);

    logic [CODE_W-1:0] w_placed;

    always_comb begin
        w_placed = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_placed[c_data_bit[i]] = i_data[i];
        end
        // Parity slots of w_placed are zero, so they do not disturb the XOR.
        o_code = w_placed;
        for (int p = 0; p < 4; p++) begin
            o_code[c_par_bit[p]] = ^(w_placed & c_par_mask[p]);
        end
    end

endmodule : hamming1511_encoder
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Round-robin winner search starting at i_ptr, wrapping to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [PTR_W-1:0] o_idx
);

    logic [PTR_W:0] w_sum;

    // Walk distances from farthest to nearest so the nearest valid one wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= (PTR_W + 1)'(NREQ)) begin
                w_sum = w_sum - (PTR_W + 1)'(NREQ);
            end
            if (i_req[w_sum[PTR_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_sum[PTR_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/hamming_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hamming_tx_arbiter
// Description : Round-robin arbiter feeding a shared Hamming(15,11) encoder
//               into a single-entry, full-throughput output register.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_tx_arbiter
    import hamming_tx_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int SEQ_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    output logic [CODE_W-1:0]        out_code,
    output logic [$clog2(NREQ)-1:0]  out_src,
    output logic [SEQ_W-1:0]         out_seq,
    input  logic                     out_ready
);

    localparam int SRC_W = $clog2(NREQ);

    logic              r_out_valid;
    logic [CODE_W-1:0] r_out_code;
    logic [SRC_W-1:0]  r_out_src;
    logic [SEQ_W-1:0]  r_out_seq;
    logic [SRC_W-1:0]  r_ptr;
    logic [SEQ_W-1:0]  r_seq;

    logic              w_can_load;
    logic              w_pick_valid;
    logic [SRC_W-1:0]  w_pick_idx;
    logic              w_grant;
    logic [SRC_W-1:0]  w_ptr_next;
    logic [DATA_W-1:0] w_req_words [NREQ];
    logic [CODE_W-1:0] w_code;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_req_words[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (SRC_W)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    hamming1511_encoder u_encoder (
        .i_data (w_req_words[w_pick_idx]),
        .o_code (w_code)
    );

    // rst_n gates the grant so req_ready is low throughout reset.
    assign w_can_load = !r_out_valid || out_ready;
    assign w_grant    = rst_n && en && w_can_load && w_pick_valid;
    assign w_ptr_next = (w_pick_idx == SRC_W'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;

    for (genvar i = 0; i < NREQ; i++) begin : g_ready
        assign req_ready[i] = w_grant && (w_pick_idx == SRC_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_src   <= '0;
            r_out_seq   <= '0;
            r_ptr       <= '0;
            r_seq       <= '0;
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_code  <= w_code;
            r_out_src   <= w_pick_idx;
            r_out_seq   <= r_seq;
            r_seq       <= r_seq + 1'b1;
            r_ptr       <= w_ptr_next;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign out_src   = r_out_src;
    assign out_seq   = r_out_seq;

endmodule : hamming_tx_arbiter
`default_nettype wire

// File: tb/tb_hamming_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_tx_arbiter
// Description : Directed self-checking bench for hamming_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int SEQ_W = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [NREQ-1:0]  req_valid;
    logic [11*NREQ-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             out_valid;
    logic [14:0]      out_code;
    logic [1:0]       out_src;
    logic [SEQ_W-1:0] out_seq;
    logic             out_ready;

    int checks;
    int failures;

    hamming_tx_arbiter #(
        .NREQ  (NREQ),
        .SEQ_W (SEQ_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_src   (out_src),
        .out_seq   (out_seq),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Reference encoder written from the parity equations.
    function automatic logic [14:0] enc_ref(input logic [10:0] d);
        logic [14:0] c;
        c[0]  = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10];
        c[1]  = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[10];
        c[2]  = d[0];
        c[3]  = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[10];
        c[4]  = d[1];
        c[5]  = d[2];
        c[6]  = d[3];
        c[7]  = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[10];
        c[14:8] = d[10:4];
        return c;
    endfunction

    function automatic logic [3:0] syndrome(input logic [14:0] c);
        logic [3:0] s;
        s = 4'd0;
        for (int j = 0; j < 15; j++) if (c[j]) s = s ^ 4'(j + 1);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        en        = 1'b1;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; out_ready = 1'b1;
        req_valid = 4'hF; req_data = '1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_code !== 15'h0) begin failures++; $display("FAIL reset_code: got %h expected 0000", out_code); end
        checks++; if (out_src !== 2'd0) begin failures++; $display("FAIL reset_src: got %0d expected 0", out_src); end
        checks++; if (out_seq !== 8'd0) begin failures++; $display("FAIL reset_seq: got %0d expected 0", out_seq); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got %b expected 0", out_valid); end
    endtask

    task automatic test_single();
        req_data = '0; req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready0: got %b expected 0001", req_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_code !== 15'h0000 || out_src !== 2'd0 || out_seq !== 8'd0) begin
            failures++; $display("FAIL single_word0: got v=%b code=%h src=%0d seq=%0d expected v=1 code=0000 src=0 seq=0", out_valid, out_code, out_src, out_seq); end
        req_data[10:0] = 11'h7FF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready1: got %b expected 0001", req_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_code !== 15'h7FFF || out_src !== 2'd0 || out_seq !== 8'd1) begin
            failures++; $display("FAIL single_word1: got v=%b code=%h src=%0d seq=%0d expected v=1 code=7fff src=0 seq=1", out_valid, out_code, out_src, out_seq); end
        req_valid = '0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain: got %b expected 0", out_valid); end
    endtask

    // Hand-encoded words through requester 2 while other slots carry junk.
    task automatic test_encode_vectors();
        logic [10:0] vd [3];
        logic [14:0] vc [3];
        vd = '{11'h001, 11'h400, 11'h555};
        vc = '{15'h0007, 15'h408B, 15'h552D};
        for (int n = 0; n < 3; n++) begin
            req_data = {11'h3C3, vd[n], 11'h2AA, 11'h7FF};
            req_valid = 4'b0100;
            #1;
            checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL enc_ready[%0d]: got %b expected 0100", n, req_ready); end
            tick();
            checks++; if (out_code !== vc[n] || out_src !== 2'd2 || out_seq !== 8'(2 + n)) begin
                failures++; $display("FAIL enc_word[%0d]: got code=%h src=%0d seq=%0d expected code=%h src=2 seq=%0d", n, out_code, out_src, out_seq, vc[n], 2 + n); end
        end
        req_valid = '0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL enc_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int j = 0; j < NREQ; j++) req_data[j*11 +: 11] = 11'(11'h100 + j);
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << (n % 4))) begin failures++; $display("FAIL rr_ready[%0d]: got %b expected %b", n, req_ready, 4'(1 << (n % 4))); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'(n % 4) || out_seq !== 8'(n) || out_code !== enc_ref(11'(11'h100 + n % 4))) begin
                failures++; $display("FAIL rr_word[%0d]: got v=%b src=%0d seq=%0d code=%h expected v=1 src=%0d seq=%0d code=%h", n, out_valid, out_src, out_seq, out_code, n % 4, n, enc_ref(11'(11'h100 + n % 4))); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d]: got %b expected 0000", n, req_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_seq !== 8'd4 || out_code !== enc_ref(11'h100)) begin
                failures++; $display("FAIL bp_hold[%0d]: got v=%b src=%0d seq=%0d code=%h expected v=1 src=0 seq=4 code=%h", n, out_valid, out_src, out_seq, out_code, enc_ref(11'h100)); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
        tick();
        checks++; if (out_src !== 2'd1 || out_seq !== 8'd5 || out_code !== enc_ref(11'h101)) begin
            failures++; $display("FAIL bp_release_word: got src=%0d seq=%0d code=%h expected src=1 seq=5 code=%h", out_src, out_seq, out_code, enc_ref(11'h101)); end
    endtask

    task automatic test_enable();
        en = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL en_ready: got %b expected 0000", req_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL en_drain: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL en_idle: got v=%b ready=%b expected v=0 ready=0000", out_valid, req_ready); end
        en = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL en_resume_ready: got %b expected 0100", req_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd2 || out_seq !== 8'd6) begin
            failures++; $display("FAIL en_resume_word: got v=%b src=%0d seq=%0d expected v=1 src=2 seq=6", out_valid, out_src, out_seq); end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_code !== 15'h0 || out_src !== 2'd0 || out_seq !== 8'd0 || req_ready !== 4'b0000) begin
            failures++; $display("FAIL async_reset: got v=%b code=%h src=%0d seq=%0d ready=%b expected all zero", out_valid, out_code, out_src, out_seq, req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL async_ready: got %b expected 0001", req_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_seq !== 8'd0) begin
            failures++; $display("FAIL async_first: got v=%b src=%0d seq=%0d expected v=1 src=0 seq=0", out_valid, out_src, out_seq); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_seq_wrap();
        logic [10:0] d;
        logic [10:0] exp_d;
        int          b;
        do_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 257; k++) begin
            d = 11'(k * 37 + 5);
            for (int j = 0; j < NREQ; j++) req_data[j*11 +: 11] = d ^ 11'(j * 273);
            exp_d = d ^ 11'((k % 4) * 273);
            #1;
            checks++; if (req_ready !== 4'(1 << (k % 4))) begin failures++; $display("FAIL wrap_ready[%0d]: got %b expected %b", k, req_ready, 4'(1 << (k % 4))); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_seq !== 8'(k) || out_src !== 2'(k % 4)) begin
                failures++; $display("FAIL wrap_hdr[%0d]: got v=%b seq=%0d src=%0d expected v=1 seq=%0d src=%0d", k, out_valid, out_seq, out_src, k % 256, k % 4); end
            checks++; if (out_code !== enc_ref(exp_d)) begin failures++; $display("FAIL wrap_code[%0d]: got %h expected %h", k, out_code, enc_ref(exp_d)); end
            checks++; if (syndrome(out_code) !== 4'd0) begin failures++; $display("FAIL wrap_syn[%0d]: got %0d expected 0", k, syndrome(out_code)); end
            b = k % 15;
            checks++; if (syndrome(out_code ^ 15'(1 << b)) !== 4'(b + 1)) begin
                failures++; $display("FAIL wrap_flip[%0d]: got %0d expected %0d", k, syndrome(out_code ^ 15'(1 << b)), b + 1); end
        end
        req_valid = '0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_drain: got %b expected 0", out_valid); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_encode_vectors();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_async_reset();
        test_seq_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hamming_tx_arbiter
`default_nettype wire
